// File: rtl/adc_frame_packer_pkg.sv
// ============================================================================
// Module   : adc_frame_pkg
// Brief    : Shared header layout, flag indices and state encoding for the
//            ADC frame packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_frame_pkg;

  localparam logic [7:0] MARKER_DEFAULT = 8'hA5;
  localparam int         SEQ_WIDTH      = 16;

  localparam int FLAG_OVF     = 0;
  localparam int FLAG_SPACING = 1;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t HDR  = 2'd1;
  localparam state_t DATA = 2'd2;
  localparam state_t TRL  = 2'd3;

  typedef struct packed {
    logic [7:0]           marker;
    logic [7:0]           flags;
    logic [SEQ_WIDTH-1:0] seq;
  } header_t;

  // Single source of the host-visible header word layout.
  function automatic logic [31:0] make_header(input logic [7:0]  marker,
                                              input logic [1:0]  flags,
                                              input logic [15:0] seq);
    header_t h;
    h.marker = marker;
    h.flags  = {6'b0, flags};
    h.seq    = seq;
    return h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_frame_packer_if.sv
// ============================================================================
// Module   : adc_frame_packer_if
// Brief    : Sample-in / FIFO-out bus of the ADC frame packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_frame_packer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_full;
  logic [31:0] out_data;
  logic        out_wr;

  modport master (
    input  in_data,
    input  in_valid,
    input  out_full,
    output out_data,
    output out_wr
  );

  modport slave (
    output in_data,
    output in_valid,
    output out_full,
    input  out_data,
    input  out_wr
  );
endinterface

`default_nettype wire

// File: rtl/adc_frame_packer.sv
// ============================================================================
// Module   : adc_frame_packer
// Brief    : Packs the ADC sample stream into header-led fixed-length frames,
//            dropping and counting samples on FIFO overflow.
//            Optional macro ADC_FRAME_TRAILER_EN adds an XOR trailer word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int         FRAME_LEN = 256,
  parameter int         SEQ_W     = 16,
  parameter logic [7:0] MARKER    = adc_frame_pkg::MARKER_DEFAULT
) (
  input  wire logic          capture_clk,
  input  wire logic          capture_rst_n,
  input  wire logic          enable,
  adc_frame_packer_if.master bus,
  output logic [15:0]        drop_count,
  output logic               frame_active
);

  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

  state_t           r_state;
  logic [SEQ_W-1:0] r_seq;
  logic [1:0]       r_flags;
  logic [15:0]      r_count;
  logic [31:0]      r_hold;
  logic             r_enable_d;
`ifdef ADC_FRAME_TRAILER_EN
  logic [31:0]      r_acc;
`endif

  logic             w_rise;
  logic [SEQ_W-1:0] w_seq;
  logic [1:0]       w_flags;
  logic [15:0]      w_drops;
  logic [15:0]      w_drops_inc;

  // A rising enable restarts numbering; these views let the same cycle's
  // decision see the cleared values.
  assign w_rise      = enable & ~r_enable_d;
  assign w_seq       = w_rise ? '0 : r_seq;
  assign w_flags     = w_rise ? 2'b00 : r_flags;
  assign w_drops     = w_rise ? 16'd0 : drop_count;
  assign w_drops_inc = (w_drops == 16'hFFFF) ? w_drops : w_drops + 16'd1;

  assign frame_active = (r_state != IDLE);

  always_ff @(posedge capture_clk or negedge capture_rst_n) begin
    if (!capture_rst_n) begin
      r_state      <= IDLE;
      r_seq        <= '0;
      r_flags      <= 2'b00;
      r_count      <= 16'd0;
      r_hold       <= 32'd0;
      r_enable_d   <= 1'b0;
      drop_count   <= 16'd0;
      bus.out_data <= 32'd0;
      bus.out_wr   <= 1'b0;
`ifdef ADC_FRAME_TRAILER_EN
      r_acc        <= 32'd0;
`endif
    end else begin
      r_enable_d <= enable;
      bus.out_wr <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
      end else begin
        if (w_rise) begin
          r_seq      <= '0;
          r_flags    <= 2'b00;
          drop_count <= 16'd0;
        end
        case (r_state)
          IDLE: begin
            if (bus.in_valid) begin
              if (!bus.out_full) begin
                bus.out_data <= make_header(MARKER, w_flags, w_seq);
                bus.out_wr   <= 1'b1;
                r_hold       <= bus.in_data;
                r_flags      <= 2'b00;
                r_state      <= HDR;
              end else begin
                r_flags[FLAG_OVF] <= 1'b1;
                drop_count        <= w_drops_inc;
              end
            end
          end
          HDR: begin
            bus.out_data <= r_hold;
            bus.out_wr   <= 1'b1;
            r_count      <= 16'd1;
            r_state      <= DATA;
`ifdef ADC_FRAME_TRAILER_EN
            r_acc        <= r_hold;
`endif
            if (bus.in_valid) begin
              r_flags[FLAG_SPACING] <= 1'b1;
              drop_count            <= w_drops_inc;
            end
          end
          DATA: begin
            if (bus.in_valid) begin
              if (!bus.out_full) begin
                bus.out_data <= bus.in_data;
                bus.out_wr   <= 1'b1;
                r_count      <= r_count + 16'd1;
`ifdef ADC_FRAME_TRAILER_EN
                r_acc        <= r_acc ^ bus.in_data;
`endif
                if (r_count == LAST_CNT) begin
                  r_seq   <= r_seq + 1'b1;
`ifdef ADC_FRAME_TRAILER_EN
                  r_state <= TRL;
`else
                  r_state <= IDLE;
`endif
                end
              end else begin
                // Abandon the frame; the next header reports the truncation.
                r_flags[FLAG_OVF] <= 1'b1;
                drop_count        <= w_drops_inc;
                r_seq             <= r_seq + 1'b1;
                r_state           <= IDLE;
              end
            end
          end
`ifdef ADC_FRAME_TRAILER_EN
          TRL: begin
            bus.out_data <= r_acc;
            bus.out_wr   <= 1'b1;
            r_state      <= IDLE;
            if (bus.in_valid) begin
              r_flags[FLAG_SPACING] <= 1'b1;
              drop_count            <= w_drops_inc;
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_packer.sv
// ============================================================================
// Module   : tb_adc_frame_packer
// Brief    : Self-checking bench for adc_frame_packer with FRAME_LEN=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_frame_packer;

  localparam int FLEN = 4;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] drop_count;
  logic        frame_active;

  adc_frame_packer_if bus();

  adc_frame_packer #(.FRAME_LEN(FLEN)) dut (
    .capture_clk   (clk),
    .capture_rst_n (rst_n),
    .enable        (enable),
    .bus           (bus),
    .drop_count    (drop_count),
    .frame_active  (frame_active)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tb_acc;
  logic [31:0] mon_exp;

  // Scoreboard: every FIFO write must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && bus.out_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_word: got write %08h, required no write", bus.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.out_data !== mon_exp) begin
          fails++;
          $display("FAIL out_word: got %08h, required %08h", bus.out_data, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] d, input logic full);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.out_full = full;
    tick(1);
    bus.in_valid = 1'b0;
    bus.out_full = 1'b0;
    tick(3);
  endtask

  task automatic exp_hdr(input logic [31:0] w);
    tb_acc = 32'd0;
    exp_q.push_back(w);
  endtask

  task automatic exp_dat(input logic [31:0] d);
    tb_acc = tb_acc ^ d;
    exp_q.push_back(d);
  endtask

  task automatic exp_end();
`ifdef ADC_FRAME_TRAILER_EN
    exp_q.push_back(tb_acc);
`endif
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_full = 1'b0;
    bus.in_data  = 32'd0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    exp_q.delete();
  endtask

  task automatic start();
    do_reset();
    enable = 1'b1;
    tick(2);
  endtask

  task automatic check_end(input string name, input logic [15:0] drops);
    tick(2);
    checks++;
    if (drop_count !== drops) begin
      fails++;
      $display("FAIL %s drop_count: got %0d, required %0d", name, drop_count, drops);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s pending_words: got %0d outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic run_frame(input logic [31:0] hdr, input logic [31:0] base);
    for (int i = 0; i < FLEN; i++) begin
      if (i == 0) exp_hdr(hdr);
      exp_dat(base + 32'(i));
      if (i == FLEN - 1) exp_end();
      strobe(base + 32'(i), 1'b0);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_full = 1'b0;
    bus.in_data  = 32'd0;
    rst_n = 1'b0;
    tick(2);
    checks++;
    if (bus.out_data !== 32'd0) begin
      fails++; $display("FAIL reset out_data: got %08h, required 0", bus.out_data);
    end
    checks++;
    if (bus.out_wr !== 1'b0) begin
      fails++; $display("FAIL reset out_wr: got %b, required 0", bus.out_wr);
    end
    checks++;
    if (drop_count !== 16'd0) begin
      fails++; $display("FAIL reset drop_count: got %0d, required 0", drop_count);
    end
    checks++;
    if (frame_active !== 1'b0) begin
      fails++; $display("FAIL reset frame_active: got %b, required 0", frame_active);
    end
  endtask

  task automatic test_normal();
    start();
    run_frame(32'hA500_0000, 32'h11);
    run_frame(32'hA500_0001, 32'h15);
    check_end("normal", 16'd0);
  endtask

  task automatic test_overflow();
    start();
    exp_hdr(32'hA500_0000);
    exp_dat(32'h21); strobe(32'h21, 1'b0);
    exp_dat(32'h22); strobe(32'h22, 1'b0);
    strobe(32'h23, 1'b1);
    checks++;
    if (frame_active !== 1'b0) begin
      fails++; $display("FAIL overflow frame_active: got %b, required 0", frame_active);
    end
    run_frame(32'hA501_0001, 32'h24);
    check_end("overflow", 16'd1);
  endtask

  task automatic test_spacing();
    start();
    exp_hdr(32'hA500_0000);
    exp_dat(32'h31);
    bus.in_data  = 32'h31;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_data  = 32'h32;
    tick(1);
    bus.in_valid = 1'b0;
    tick(3);
    exp_dat(32'h33); strobe(32'h33, 1'b0);
    exp_dat(32'h34); strobe(32'h34, 1'b0);
    exp_dat(32'h35); exp_end(); strobe(32'h35, 1'b0);
    run_frame(32'hA502_0001, 32'h36);
    exp_hdr(32'hA500_0002);
    exp_dat(32'h3A); strobe(32'h3A, 1'b0);
    check_end("spacing", 16'd1);
  endtask

  task automatic test_wrap();
    start();
    force dut.r_seq = 16'hFFFF;
    tick(1);
    release dut.r_seq;
    tick(1);
    run_frame(32'hA500_FFFF, 32'h61);
    run_frame(32'hA500_0000, 32'h65);
    check_end("wrap", 16'd0);
  endtask

  task automatic test_enable_drop();
    start();
    run_frame(32'hA500_0000, 32'h71);
    exp_hdr(32'hA500_0001);
    exp_dat(32'h75); strobe(32'h75, 1'b0);
    enable = 1'b0;
    tick(1);
    checks++;
    if (frame_active !== 1'b0) begin
      fails++; $display("FAIL enable_drop frame_active: got %b, required 0", frame_active);
    end
    strobe(32'h76, 1'b0);
    enable = 1'b1;
    tick(3);
    check_end("enable_idle", 16'd0);
    exp_hdr(32'hA500_0000);
    exp_dat(32'h77); strobe(32'h77, 1'b0);
    check_end("enable_restart", 16'd0);
  endtask

  task automatic test_async_reset();
    bus.in_data  = 32'h78;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_wr !== 1'b1) begin
      fails++; $display("FAIL async_pre out_wr: got %b, required 1", bus.out_wr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_wr !== 1'b0) begin
      fails++; $display("FAIL async out_wr: got %b, required 0", bus.out_wr);
    end
    checks++;
    if (bus.out_data !== 32'd0) begin
      fails++; $display("FAIL async out_data: got %08h, required 0", bus.out_data);
    end
    checks++;
    if (frame_active !== 1'b0) begin
      fails++; $display("FAIL async frame_active: got %b, required 0", frame_active);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

`ifdef ADC_FRAME_TRAILER_EN
  task automatic test_trailer();
    start();
    exp_hdr(32'hA500_0000);
    exp_dat(32'h1); strobe(32'h1, 1'b0);
    exp_dat(32'h2); strobe(32'h2, 1'b0);
    exp_dat(32'h4); strobe(32'h4, 1'b0);
    exp_dat(32'h8);
    exp_q.push_back(32'h0000_000F);
    strobe(32'h8, 1'b0);
    exp_hdr(32'hA500_0001);
    exp_dat(32'h1); strobe(32'h1, 1'b0);
    exp_dat(32'h2); strobe(32'h2, 1'b0);
    strobe(32'h3, 1'b1);
    tick(4);
    check_end("truncated_no_trailer", 16'd1);
    exp_hdr(32'hA501_0002);
    exp_dat(32'h5); strobe(32'h5, 1'b0);
    check_end("trailer_next", 16'd1);
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_spacing();
    test_wrap();
    test_enable_drop();
    test_async_reset();
`ifdef ADC_FRAME_TRAILER_EN
    test_trailer();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
